// File: rtl/ex_stage.sv
// Execute stage: ALU, EX-side forwarding and a multicycle mult/div unit
// with HI/LO, registering the EX/MEM bundle consumed by MEM.
package ex_pkg;
   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_NOR  = 4'd5;
   localparam logic [3:0] ALU_SLT  = 4'd6;
   localparam logic [3:0] ALU_SLTU = 4'd7;
   localparam logic [3:0] ALU_SLL  = 4'd8;
   localparam logic [3:0] ALU_SRL  = 4'd9;
   localparam logic [3:0] ALU_SRA  = 4'd10;
   localparam logic [3:0] ALU_LUI  = 4'd11;

   localparam logic [3:0] MD_MULT  = 4'd1;
   localparam logic [3:0] MD_MULTU = 4'd2;
   localparam logic [3:0] MD_DIV   = 4'd3;
   localparam logic [3:0] MD_DIVU  = 4'd4;
   localparam logic [3:0] MD_MFHI  = 4'd5;
   localparam logic [3:0] MD_MFLO  = 4'd6;
   localparam logic [3:0] MD_MTHI  = 4'd7;
   localparam logic [3:0] MD_MTLO  = 4'd8;

   typedef enum logic {
      MD_IDLE,
      MD_BUSY
   } md_state_e;
endpackage

module ex_stage
   import ex_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        EX_FLUSH,
   input  logic [8:0]  EX_CTRL,
   input  logic        MEM_CTRL,
   input  logic [4:0]  WB_CTRL,
   input  logic [4:0]  rs_idx,
   input  logic [4:0]  rt_idx,
   input  logic [31:0] rd1,
   input  logic [31:0] rd2,
   input  logic [31:0] imm,
   input  logic [4:0]  rw,
   input  logic [37:0] i_MEM_BACK,
   input  logic [37:0] i_WB_BACK,
   output logic        md_stall,
   output logic        o_MEM_CTRL,
   output logic [4:0]  o_WB_CTRL,
   output logic [68:0] o_MEM_DATA
);

   localparam int unsigned CNT_MAX =
      (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW = $clog2(CNT_MAX + 1);

   logic [3:0]  w_alu_op;
   logic        w_alu_src;
   logic [3:0]  w_md_op;

   assign w_alu_op  = EX_CTRL[8:5];
   assign w_alu_src = EX_CTRL[4];
   assign w_md_op   = EX_CTRL[3:0];

   logic        w_mem_we;
   logic [31:0] w_mem_wd;
   logic [4:0]  w_mem_rw;
   logic        w_wb_we;
   logic [31:0] w_wb_wd;
   logic [4:0]  w_wb_rw;

   assign w_mem_we = i_MEM_BACK[37];
   assign w_mem_wd = i_MEM_BACK[36:5];
   assign w_mem_rw = i_MEM_BACK[4:0];
   assign w_wb_we  = i_WB_BACK[37];
   assign w_wb_wd  = i_WB_BACK[36:5];
   assign w_wb_rw  = i_WB_BACK[4:0];

   logic w_mem_hit_rs;
   logic w_mem_hit_rt;
   logic w_wb_hit_rs;
   logic w_wb_hit_rt;

   assign w_mem_hit_rs = w_mem_we && (w_mem_rw != 5'd0)
                         && (w_mem_rw == rs_idx);
   assign w_mem_hit_rt = w_mem_we && (w_mem_rw != 5'd0)
                         && (w_mem_rw == rt_idx);
   assign w_wb_hit_rs  = w_wb_we && (w_wb_rw != 5'd0)
                         && (w_wb_rw == rs_idx);
   assign w_wb_hit_rt  = w_wb_we && (w_wb_rw != 5'd0)
                         && (w_wb_rw == rt_idx);

   // MEM is younger than WB, so its value wins
   logic [31:0] w_a;
   logic [31:0] w_rt;
   logic [31:0] w_b;

   assign w_a  = w_mem_hit_rs ? w_mem_wd :
                 w_wb_hit_rs  ? w_wb_wd  : rd1;
   assign w_rt = w_mem_hit_rt ? w_mem_wd :
                 w_wb_hit_rt  ? w_wb_wd  : rd2;
   assign w_b  = w_alu_src ? imm : w_rt;

   logic [31:0] w_alu;

   always_comb begin
      w_alu = '0;
      unique case (w_alu_op)
         ALU_ADD:  w_alu = w_a + w_b;
         ALU_SUB:  w_alu = w_a - w_b;
         ALU_AND:  w_alu = w_a & w_b;
         ALU_OR:   w_alu = w_a | w_b;
         ALU_XOR:  w_alu = w_a ^ w_b;
         ALU_NOR:  w_alu = ~(w_a | w_b);
         ALU_SLT:  w_alu = {31'd0, $signed(w_a) < $signed(w_b)};
         ALU_SLTU: w_alu = {31'd0, w_a < w_b};
         ALU_SLL:  w_alu = w_b << w_a[4:0];
         ALU_SRL:  w_alu = w_b >> w_a[4:0];
         ALU_SRA:  w_alu = $signed(w_b) >>> w_a[4:0];
         ALU_LUI:  w_alu = {w_b[15:0], 16'd0};
         default:  w_alu = '0;
      endcase
   end

   logic        w_md_any;
   logic        w_md_arith;
   logic        w_md_is_mul;
   logic        w_busy;
   logic        w_go;
   logic        w_issue;
   logic        w_mthi;
   logic        w_mtlo;

   assign w_md_any    = (w_md_op >= MD_MULT) && (w_md_op <= MD_MTLO);
   assign w_md_arith  = (w_md_op >= MD_MULT) && (w_md_op <= MD_DIVU);
   assign w_md_is_mul = (w_md_op == MD_MULT) || (w_md_op == MD_MULTU);

   assign md_stall = w_busy && w_md_any && !EX_FLUSH;
   assign w_go     = !EX_FLUSH && !w_busy;
   assign w_issue  = w_go && w_md_arith;
   assign w_mthi   = w_go && (w_md_op == MD_MTHI);
   assign w_mtlo   = w_go && (w_md_op == MD_MTLO);

   logic [63:0] w_prod_s;
   logic [63:0] w_prod_u;
   logic        w_div_zero;
   logic        w_div_ovf;
   logic [31:0] w_dvs;
   logic [31:0] w_quot_s;
   logic [31:0] w_rem_s;
   logic [31:0] w_quot_u;
   logic [31:0] w_rem_u;

   assign w_prod_s = {{32{w_a[31]}}, w_a} * {{32{w_rt[31]}}, w_rt};
   assign w_prod_u = {32'd0, w_a} * {32'd0, w_rt};

   // divisor is steered to 1 for /0 and INT_MIN/-1; both are exact or unused
   assign w_div_zero = (w_rt == 32'd0);
   assign w_div_ovf  = (w_a == 32'h8000_0000) && (w_rt == 32'hFFFF_FFFF);
   assign w_dvs      = (w_div_zero || w_div_ovf) ? 32'd1 : w_rt;
   assign w_quot_s   = $signed(w_a) / $signed(w_dvs);
   assign w_rem_s    = $signed(w_a) % $signed(w_dvs);
   assign w_quot_u   = w_a / w_dvs;
   assign w_rem_u    = w_a % w_dvs;

   logic [31:0] w_pend_hi_nx;
   logic [31:0] w_pend_lo_nx;
   logic        w_pend_we_nx;

   always_comb begin
      w_pend_hi_nx = '0;
      w_pend_lo_nx = '0;
      w_pend_we_nx = 1'b1;
      unique case (1'b1)
         (w_md_op == MD_MULT):  {w_pend_hi_nx, w_pend_lo_nx} = w_prod_s;
         (w_md_op == MD_MULTU): {w_pend_hi_nx, w_pend_lo_nx} = w_prod_u;
         (w_md_op == MD_DIV): begin
            w_pend_hi_nx = w_rem_s;
            w_pend_lo_nx = w_quot_s;
            w_pend_we_nx = !w_div_zero;
         end
         (w_md_op == MD_DIVU): begin
            w_pend_hi_nx = w_rem_u;
            w_pend_lo_nx = w_quot_u;
            w_pend_we_nx = !w_div_zero;
         end
         default: w_pend_we_nx = 1'b0;
      endcase
   end

   md_state_e   r_state;
   md_state_e   w_state_nx;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nx;
   logic        w_commit;

   assign w_busy = (r_state == MD_BUSY);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= MD_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_commit   = 1'b0;
      unique case (r_state)
         MD_IDLE: begin
            if (w_issue) begin
               w_state_nx = MD_BUSY;
               w_cnt_nx   = w_md_is_mul ? CW'(MULT_CYCLES)
                                        : CW'(DIV_CYCLES);
            end
         end
         MD_BUSY: begin
            w_cnt_nx = r_cnt - CW'(1);
            if (r_cnt <= CW'(1)) begin
               w_commit   = 1'b1;
               w_state_nx = MD_IDLE;
               w_cnt_nx   = '0;
            end
         end
      endcase
   end

   logic [31:0] r_hi;
   logic [31:0] r_lo;
   logic [31:0] r_pend_hi;
   logic [31:0] r_pend_lo;
   logic        r_pend_we;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hi      <= '0;
         r_lo      <= '0;
         r_pend_hi <= '0;
         r_pend_lo <= '0;
         r_pend_we <= 1'b0;
      end else begin
         if (w_issue) begin
            r_pend_hi <= w_pend_hi_nx;
            r_pend_lo <= w_pend_lo_nx;
            r_pend_we <= w_pend_we_nx;
         end
         if (w_commit && r_pend_we) begin
            r_hi <= r_pend_hi;
            r_lo <= r_pend_lo;
         end else if (w_mthi) begin
            r_hi <= w_a;
         end else if (w_mtlo) begin
            r_lo <= w_a;
         end
      end
   end

   logic [31:0] w_exout;

   assign w_exout = (w_md_op == MD_MFHI) ? r_hi :
                    (w_md_op == MD_MFLO) ? r_lo : w_alu;

   always_ff @(posedge clk) begin
      if (rst) begin
         o_MEM_CTRL <= 1'b0;
         o_WB_CTRL  <= '0;
         o_MEM_DATA <= '0;
      end else begin
         o_MEM_DATA <= {rw, w_exout, w_rt};
         if (EX_FLUSH || md_stall) begin
            o_MEM_CTRL <= 1'b0;
            o_WB_CTRL  <= '0;
         end else begin
            o_MEM_CTRL <= MEM_CTRL;
            o_WB_CTRL  <= WB_CTRL;
         end
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed and random instructions against a
// behavioural model, EX/MEM bundle checked through a scoreboard queue.
module tb_ex_stage;
   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        EX_FLUSH = 1'b0;
   logic [8:0]  EX_CTRL = '0;
   logic        MEM_CTRL = 1'b0;
   logic [4:0]  WB_CTRL = '0;
   logic [4:0]  rs_idx = '0;
   logic [4:0]  rt_idx = '0;
   logic [31:0] rd1 = '0;
   logic [31:0] rd2 = '0;
   logic [31:0] imm = '0;
   logic [4:0]  rw = '0;
   logic [37:0] i_MEM_BACK = '0;
   logic [37:0] i_WB_BACK = '0;
   logic        md_stall;
   logic        o_MEM_CTRL;
   logic [4:0]  o_WB_CTRL;
   logic [68:0] o_MEM_DATA;

   ex_stage #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .rst(rst), .EX_FLUSH(EX_FLUSH), .EX_CTRL(EX_CTRL),
      .MEM_CTRL(MEM_CTRL), .WB_CTRL(WB_CTRL), .rs_idx(rs_idx),
      .rt_idx(rt_idx), .rd1(rd1), .rd2(rd2), .imm(imm), .rw(rw),
      .i_MEM_BACK(i_MEM_BACK), .i_WB_BACK(i_WB_BACK),
      .md_stall(md_stall), .o_MEM_CTRL(o_MEM_CTRL),
      .o_WB_CTRL(o_WB_CTRL), .o_MEM_DATA(o_MEM_DATA)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        mc;
      logic [4:0]  wb;
      logic [68:0] data;
   } exp_t;

   int          n_chk = 0;
   int          n_fail = 0;
   exp_t        sbq[$];
   int          edge_n = 0;
   int          done_edge = 0;
   int          dut_stalls = 0;
   logic        pend_we = 1'b0;
   logic [31:0] pend_hi = '0;
   logic [31:0] pend_lo = '0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   task automatic chk(input string nm, input logic [74:0] act,
                      input logic [74:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (o_WB_CTRL[0] === 1'b1) begin
         if (sbq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_unexpected: got %h required nothing",
                     {o_MEM_CTRL, o_WB_CTRL, o_MEM_DATA});
         end else begin
            chk("sb_bundle", {o_MEM_CTRL, o_WB_CTRL, o_MEM_DATA},
                sbq.pop_front());
         end
      end
   end

   function automatic logic [31:0] fwd(input logic [4:0] idx,
                                       input logic [31:0] rf);
      if (i_MEM_BACK[37] && i_MEM_BACK[4:0] != 0 && i_MEM_BACK[4:0] == idx)
         return i_MEM_BACK[36:5];
      if (i_WB_BACK[37] && i_WB_BACK[4:0] != 0 && i_WB_BACK[4:0] == idx)
         return i_WB_BACK[36:5];
      return rf;
   endfunction

   function automatic logic [31:0] alu_ref(input int op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
      longint      sa, sb, p2, q;
      logic [63:0] t;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      p2 = longint'(1) << int'(a[4:0]);
      case (op)
         0: return a + b;
         1: return a - b;
         2: return a & b;
         3: return a | b;
         4: return a ^ b;
         5: return ~(a | b);
         6: return (sa < sb) ? 32'd1 : 32'd0;
         7: return (a < b) ? 32'd1 : 32'd0;
         8: begin t = {32'd0, b} * 64'(p2); return t[31:0]; end
         9: begin t = {32'd0, b} / 64'(p2); return t[31:0]; end
         10: begin
            if (sb >= 0) q = sb / p2;
            else q = -((-sb + p2 - 1) / p2);
            return 32'(q);
         end
         11: begin t = {32'd0, b} * 64'd65536; return t[31:0]; end
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_issue(input logic [3:0] md, input logic [31:0] a,
                              input logic [31:0] rt);
      longint      sa, sb;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(rt));
      pend_we = 1'b1;
      case (md)
         4'd1: begin p = 64'(sa * sb); {pend_hi, pend_lo} = p; end
         4'd2: begin p = {32'd0, a} * {32'd0, rt}; {pend_hi, pend_lo} = p; end
         4'd3: begin
            if (rt == 0) pend_we = 1'b0;
            else begin pend_lo = 32'(sa / sb); pend_hi = 32'(sa % sb); end
         end
         default: begin
            if (rt == 0) pend_we = 1'b0;
            else begin pend_lo = a / rt; pend_hi = a % rt; end
         end
      endcase
      done_edge = edge_n + 1 + ((md <= 4'd2) ? MC : DC);
   endtask

   task automatic run(input logic [3:0] alu, input logic src,
                      input logic [3:0] md, input logic fl,
                      input logic [4:0] rsi, input logic [4:0] rti,
                      input logic [31:0] r1, input logic [31:0] r2,
                      input logic [31:0] im, input logic [4:0] dst);
      logic [31:0] a, b, rt, ex;
      logic        busy, stall, wr_hi, wr_lo;
      int          k;
      EX_CTRL = {alu, src, md};
      EX_FLUSH = fl;
      MEM_CTRL = 1'($urandom);
      WB_CTRL = {4'($urandom), 1'b1};
      rs_idx = rsi; rt_idx = rti;
      rd1 = r1; rd2 = r2; imm = im; rw = dst;
      dut_stalls = 0;
      for (k = 0; k < 40; k++) begin
         #1;
         a = fwd(rsi, r1);
         rt = fwd(rti, r2);
         b = src ? im : rt;
         busy = edge_n < done_edge;
         stall = busy && md >= 4'd1 && md <= 4'd8 && !fl;
         chk("md_stall", md_stall, stall);
         if (md_stall === 1'b1) dut_stalls++;
         wr_hi = 1'b0;
         wr_lo = 1'b0;
         if (!stall && !fl) begin
            ex = (md == 4'd5) ? m_hi :
                 (md == 4'd6) ? m_lo : alu_ref(int'(alu), a, b);
            sbq.push_back({MEM_CTRL, WB_CTRL, dst, ex, rt});
            if (!busy) begin
               if (md >= 4'd1 && md <= 4'd4) model_issue(md, a, rt);
               wr_hi = (md == 4'd7);
               wr_lo = (md == 4'd8);
            end
         end
         @(posedge clk);
         edge_n++;
         if (edge_n == done_edge && pend_we) begin
            m_hi = pend_hi;
            m_lo = pend_lo;
         end
         if (wr_hi) m_hi = a;
         if (wr_lo) m_lo = a;
         if (!stall) break;
         #1;
         chk("bubble_ctrl", {o_MEM_CTRL, o_WB_CTRL}, 0);
      end
      if (k == 40) begin
         n_chk++;
         n_fail++;
         $display("FAIL stall_timeout: got 40 stalled cycles required <%0d", DC + 2);
      end
      #1;
   endtask

   task automatic op(input logic [3:0] alu, input logic src,
                     input logic [3:0] md, input logic [31:0] r1,
                     input logic [31:0] r2, input logic [31:0] im);
      run(alu, src, md, 1'b0, 5'd1, 5'd2, r1, r2, im, 5'd7);
   endtask

   task automatic expect_ex(input string nm, input logic [31:0] v);
      chk(nm, o_MEM_DATA[63:32], v);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      EX_CTRL = {4'd0, 1'b0, 4'd5};
      @(posedge clk);
      edge_n++;
      #1;
      rst = 1'b0;
      m_hi = '0;
      m_lo = '0;
      pend_we = 1'b0;
      done_edge = edge_n;
      #1;
      chk("rst_md_stall", md_stall, 0);
      chk("rst_wb_ctrl", o_WB_CTRL, 0);
      chk("rst_mem_ctrl", o_MEM_CTRL, 0);
      chk("rst_mem_data", o_MEM_DATA, 0);
   endtask

   function automatic logic [31:0] rv();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'($urandom_range(0, 40));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      do_reset();

      i_MEM_BACK = {1'b1, 32'h10, 5'd1};
      op(4'd0, 1'b0, 4'd0, 32'd5, 32'd3, 32'd0);
      expect_ex("fwd_mem", 32'h13);
      i_WB_BACK = {1'b1, 32'h99, 5'd1};
      op(4'd0, 1'b0, 4'd0, 32'd5, 32'd3, 32'd0);
      expect_ex("fwd_mem_prio", 32'h13);
      i_MEM_BACK = {1'b1, 32'h10, 5'd0};
      i_WB_BACK = {1'b1, 32'h99, 5'd0};
      op(4'd0, 1'b0, 4'd0, 32'd5, 32'd3, 32'd0);
      expect_ex("fwd_rw0", 32'd8);
      i_MEM_BACK = '0;
      i_WB_BACK = '0;

      op(4'd10, 1'b0, 4'd0, 32'd4, 32'h8000_0000, 32'd0);
      expect_ex("sra", 32'hF800_0000);
      op(4'd6, 1'b0, 4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0);
      expect_ex("slt", 32'd1);
      op(4'd7, 1'b0, 4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0);
      expect_ex("sltu", 32'd0);
      op(4'd11, 1'b1, 4'd0, 32'd0, 32'd0, 32'h1234);
      expect_ex("lui", 32'h1234_0000);

      op(4'd0, 1'b0, 4'd1, 32'hFFFF_FFFF, 32'd2, 32'd0);
      op(4'd0, 1'b0, 4'd5, 32'd0, 32'd0, 32'd0);
      expect_ex("mult_hi", 32'hFFFF_FFFF);
      chk("mult_stall_cycles", dut_stalls, MC);
      op(4'd0, 1'b0, 4'd6, 32'd0, 32'd0, 32'd0);
      expect_ex("mult_lo", 32'hFFFF_FFFE);
      chk("mflo_no_stall", dut_stalls, 0);
      op(4'd0, 1'b0, 4'd2, 32'hFFFF_FFFF, 32'd2, 32'd0);
      op(4'd0, 1'b0, 4'd5, 32'd0, 32'd0, 32'd0);
      expect_ex("multu_hi", 32'd1);

      op(4'd0, 1'b0, 4'd3, 32'hFFFF_FFF9, 32'd2, 32'd0);
      op(4'd0, 1'b0, 4'd6, 32'd0, 32'd0, 32'd0);
      expect_ex("div_lo", 32'hFFFF_FFFD);
      chk("div_stall_cycles", dut_stalls, DC);
      op(4'd0, 1'b0, 4'd5, 32'd0, 32'd0, 32'd0);
      expect_ex("div_hi", 32'hFFFF_FFFF);
      op(4'd0, 1'b0, 4'd4, 32'd5, 32'd0, 32'd0);
      op(4'd0, 1'b0, 4'd5, 32'd0, 32'd0, 32'd0);
      expect_ex("divz_hi", 32'hFFFF_FFFF);
      chk("divz_stall_cycles", dut_stalls, DC);
      op(4'd0, 1'b0, 4'd6, 32'd0, 32'd0, 32'd0);
      expect_ex("divz_lo", 32'hFFFF_FFFD);

      op(4'd0, 1'b0, 4'd8, 32'hAA, 32'd0, 32'd0);
      op(4'd0, 1'b0, 4'd6, 32'd0, 32'd0, 32'd0);
      expect_ex("mtlo_mflo", 32'hAA);
      chk("mtlo_no_stall", dut_stalls, 0);

      op(4'd0, 1'b0, 4'd1, 32'd3, 32'd4, 32'd0);
      op(4'd0, 1'b0, 4'd0, 32'd1, 32'd2, 32'd0);
      expect_ex("add_while_busy", 32'd3);
      chk("add_busy_no_stall", dut_stalls, 0);
      op(4'd0, 1'b0, 4'd6, 32'd0, 32'd0, 32'd0);
      expect_ex("mult_lo_12", 32'd12);

      run(4'd0, 1'b0, 4'd1, 1'b1, 5'd1, 5'd2, 32'd7, 32'd7, 32'd0, 5'd7);
      op(4'd0, 1'b0, 4'd6, 32'd0, 32'd0, 32'd0);
      expect_ex("flush_no_issue", 32'd12);
      chk("flush_not_busy", dut_stalls, 0);

      op(4'd0, 1'b0, 4'd3, 32'd100, 32'd7, 32'd0);
      for (int i = 0; i < 6; i++) op(4'd0, 1'b0, 4'd0, 32'(i), 32'd1, 32'd0);
      do_reset();
      op(4'd0, 1'b0, 4'd5, 32'd0, 32'd0, 32'd0);
      expect_ex("rst_hi", 32'd0);
      chk("rst_no_stall", dut_stalls, 0);
      op(4'd0, 1'b0, 4'd6, 32'd0, 32'd0, 32'd0);
      expect_ex("rst_lo", 32'd0);

      for (int i = 0; i < 400; i++) begin
         logic [3:0] alu, md;
         alu = 4'($urandom);
         md = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
         i_MEM_BACK = {1'($urandom), rv(), 5'($urandom_range(0, 7))};
         i_WB_BACK = {1'($urandom), rv(), 5'($urandom_range(0, 7))};
         run(alu, 1'($urandom), md, ($urandom_range(0, 9) == 0),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             rv(), rv(), rv(), 5'($urandom));
      end

      op(4'd0, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0);
      @(negedge clk);
      #1;
      chk("sb_drained", sbq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
